vec_ram_arbiter: RTL

Owns the single port of the 16-bit vector RAM. That port is shared between two clients:
- CPU byte writes, arriving from the address decoder on the 3 MHz enable cadence.
- AVG instruction fetches, arriving on the fast clock.

CPU writes are captured into a small write queue. Queued writes are interleaved with AVG reads under a fixed-priority scheme with an anti-starvation bound. Sits between addrDecoder/avg_core and the vector RAM, replacing the combinational we-based address mux.

---
 rtl/vec_ram_arbiter_if.sv | 49 ++++
 rtl/vec_ram_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/vec_ram_arbiter_if.sv
// Bus bundle between the CPU write port, the AVG fetch port and the vector RAM.
// VRAM_ARB_STATS_EN adds the stall/drop statistics outputs.
interface vec_ram_arbiter_if #(
    parameter int AW = 12
);
    logic          cpu_we;
    logic [15:0]   cpu_addr;
    logic [7:0]    cpu_wdata;
    logic          avg_halt;
    logic          avg_rd_req;
    logic [15:0]   avg_rd_addr;
    logic          avg_rd_ack;
    logic          avg_rd_valid;
    logic [15:0]   avg_inst;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [1:0]    ram_be;
    logic [15:0]   ram_wdata;
    logic [15:0]   ram_rdata;
    logic          wq_full;
    logic          wq_empty;
    logic          wr_drop;
`ifdef VRAM_ARB_STATS_EN
    logic [15:0]   stall_cnt;
    logic [7:0]    drop_cnt;

    modport slave (
        input  cpu_we, cpu_addr, cpu_wdata, avg_halt, avg_rd_req, avg_rd_addr, ram_rdata,
        output avg_rd_ack, avg_rd_valid, avg_inst, ram_addr, ram_we, ram_be, ram_wdata,
        output wq_full, wq_empty, wr_drop, stall_cnt, drop_cnt
    );
    modport master (
        output cpu_we, cpu_addr, cpu_wdata, avg_halt, avg_rd_req, avg_rd_addr, ram_rdata,
        input  avg_rd_ack, avg_rd_valid, avg_inst, ram_addr, ram_we, ram_be, ram_wdata,
        input  wq_full, wq_empty, wr_drop, stall_cnt, drop_cnt
    );
`else
    modport slave (
        input  cpu_we, cpu_addr, cpu_wdata, avg_halt, avg_rd_req, avg_rd_addr, ram_rdata,
        output avg_rd_ack, avg_rd_valid, avg_inst, ram_addr, ram_we, ram_be, ram_wdata,
        output wq_full, wq_empty, wr_drop
    );
    modport master (
        output cpu_we, cpu_addr, cpu_wdata, avg_halt, avg_rd_req, avg_rd_addr, ram_rdata,
        input  avg_rd_ack, avg_rd_valid, avg_inst, ram_addr, ram_we, ram_be, ram_wdata,
        input  wq_full, wq_empty, wr_drop
    );
`endif
endinterface

// File: rtl/vec_ram_arbiter.sv
// Single-port vector RAM arbiter: queued CPU byte writes vs AVG fetches, with anti-starvation.
// Optional VRAM_ARB_STATS_EN adds saturating stall_cnt/drop_cnt statistics.
//
// state   | meaning
// ARB     | grant a queued write or an AVG fetch
// RD_WAIT | fetch address is at the RAM; no grants this cycle
module vec_ram_arbiter #(
    parameter int          WQ_DEPTH  = 4,
    parameter int          MAX_WAIT  = 8,
    parameter int          AW        = 12,
    parameter logic [15:0] VRAM_BASE = 16'h2000
) (
    input logic              clk,
    input logic              rst,
    vec_ram_arbiter_if.slave bus
);
    localparam int              PW     = $clog2(WQ_DEPTH);
    localparam int              WW     = $clog2(MAX_WAIT + 1);
    localparam logic [PW:0]     DEPTH  = (PW + 1)'(WQ_DEPTH);
    localparam logic [WW-1:0]   WAIT_N = WW'(MAX_WAIT);
    localparam logic [16:0]     SPAN   = 17'(1) << (AW + 1);

    typedef enum logic {ARB, RD_WAIT} state_t;
    state_t state, state_nx;

    logic [AW-1:0] q_idx  [WQ_DEPTH];
    logic          q_lane [WQ_DEPTH];
    logic [7:0]    q_data [WQ_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          full, empty;

    logic          cpu_we_q;
    logic          in_range, enq, enq_ok, drop;
    logic [AW-1:0] cpu_idx, rd_idx;
    logic [WW-1:0] wait_left;
    logic          wr_gnt, rd_gnt, rd_cap;

    logic [AW-1:0] ram_addr_r;
    logic          ram_we_r;
    logic [1:0]    ram_be_r;
    logic [15:0]   ram_wdata_r;
    logic          avg_rd_valid_r;
    logic [15:0]   avg_inst_r;
    logic          wr_drop_r;

    // Addresses below the base wrap to >= 2^16 in 17 bits, so one compare covers both bounds.
    assign in_range = ({1'b0, bus.cpu_addr} - {1'b0, VRAM_BASE}) < SPAN;
    assign cpu_idx  = AW'((bus.cpu_addr - VRAM_BASE) >> 1);
    assign rd_idx   = AW'((bus.avg_rd_addr - VRAM_BASE) >> 1);

    assign full   = (count == DEPTH);
    assign empty  = (count == '0);
    assign enq    = bus.cpu_we && !cpu_we_q && in_range;
    assign enq_ok = enq && (!full || wr_gnt);
    assign drop   = enq && full && !wr_gnt;

    always_comb begin
        state_nx = state;
        wr_gnt   = 1'b0;
        rd_gnt   = 1'b0;
        case (state)
            ARB: begin
                if (!empty && (bus.avg_halt || !bus.avg_rd_req || full || wait_left == '0)) begin
                    wr_gnt = 1'b1;
                end else if (bus.avg_rd_req) begin
                    rd_gnt   = 1'b1;
                    state_nx = RD_WAIT;
                end
            end
            RD_WAIT: state_nx = ARB;
            default: state_nx = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB;
            cpu_we_q  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wait_left <= WAIT_N;
            wr_drop_r <= 1'b0;
        end else begin
            state    <= state_nx;
            cpu_we_q <= bus.cpu_we;
            if (enq_ok) wr_ptr <= wr_ptr + 1'b1;
            if (wr_gnt) rd_ptr <= rd_ptr + 1'b1;
            case ({enq_ok, wr_gnt})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            // Read grants made while a write waits count down toward a forced write.
            if (wr_gnt) begin
                wait_left <= WAIT_N;
            end else if (rd_gnt && !empty && wait_left != '0) begin
                wait_left <= wait_left - 1'b1;
            end
            if (drop) wr_drop_r <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_ok) begin
            q_idx[wr_ptr]  <= cpu_idx;
            q_lane[wr_ptr] <= bus.cpu_addr[0];
            q_data[wr_ptr] <= bus.cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_addr_r     <= '0;
            ram_we_r       <= 1'b0;
            ram_be_r       <= 2'b00;
            ram_wdata_r    <= '0;
            rd_cap         <= 1'b0;
            avg_rd_valid_r <= 1'b0;
            avg_inst_r     <= '0;
        end else begin
            ram_we_r <= wr_gnt;
            if (wr_gnt) begin
                ram_addr_r  <= q_idx[rd_ptr];
                ram_be_r    <= q_lane[rd_ptr] ? 2'b01 : 2'b10;
                ram_wdata_r <= {q_data[rd_ptr], q_data[rd_ptr]};
            end else begin
                ram_be_r <= 2'b00;
                if (rd_gnt) ram_addr_r <= rd_idx;
            end
            // RAM data for the fetch issued in RD_WAIT is present one cycle after it.
            rd_cap         <= (state == RD_WAIT);
            avg_rd_valid_r <= rd_cap;
            if (rd_cap) avg_inst_r <= bus.ram_rdata;
        end
    end

    assign bus.avg_rd_ack   = rd_gnt;
    assign bus.avg_rd_valid = avg_rd_valid_r;
    assign bus.avg_inst     = avg_inst_r;
    assign bus.ram_addr     = ram_addr_r;
    assign bus.ram_we       = ram_we_r;
    assign bus.ram_be       = ram_be_r;
    assign bus.ram_wdata    = ram_wdata_r;
    assign bus.wq_full      = full;
    assign bus.wq_empty     = empty;
    assign bus.wr_drop      = wr_drop_r;

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] stall_cnt_r;
    logic [7:0]  drop_cnt_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= '0;
            drop_cnt_r  <= '0;
        end else begin
            if (wr_gnt && bus.avg_rd_req && stall_cnt_r != 16'hFFFF) stall_cnt_r <= stall_cnt_r + 1'b1;
            if (drop && drop_cnt_r != 8'hFF) drop_cnt_r <= drop_cnt_r + 1'b1;
        end
    end

    assign bus.stall_cnt = stall_cnt_r;
    assign bus.drop_cnt  = drop_cnt_r;
`endif
endmodule
